// File: rtl/axi4_mem_slave.sv
// AXI4 INCR-burst slave driving a single-port memory; one FSM serialises write and read bursts.
// Optional out-of-range word checking is enabled by defining AXI_MEM_RANGE_CHK_EN.
module axi4_mem_slave #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int DEPTH      = 1024
) (
    input  logic                     ACLK,
    input  logic                     ARESETn,
    input  logic [ADDR_WIDTH-1:0]    AWADDR,
    input  logic [7:0]               AWLEN,
    input  logic                     AWVALID,
    output logic                     AWREADY,
    input  logic [DATA_WIDTH-1:0]    WDATA,
    input  logic                     WLAST,
    input  logic                     WVALID,
    output logic                     WREADY,
    output logic [1:0]               BRESP,
    output logic                     BVALID,
    input  logic                     BREADY,
    input  logic [ADDR_WIDTH-1:0]    ARADDR,
    input  logic [7:0]               ARLEN,
    input  logic                     ARVALID,
    output logic                     ARREADY,
    output logic [DATA_WIDTH-1:0]    RDATA,
    output logic [1:0]               RRESP,
    output logic                     RLAST,
    output logic                     RVALID,
    input  logic                     RREADY,
    output logic                     mem_en,
    output logic                     mem_we,
    output logic [$clog2(DEPTH)-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]    mem_wdata,
    input  logic [DATA_WIDTH-1:0]    mem_rdata
);

    localparam int AW_M = $clog2(DEPTH);
    localparam int OFFS = $clog2(DATA_WIDTH / 8);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {IDLE, WR_DATA, WR_RESP, RD_ISSUE, RD_WAIT, RD_HOLD} state_t;
    typedef enum logic {RR_WRITE, RR_READ} rr_t;

    state_t                state;
    rr_t                   rr_last;
    logic [ADDR_WIDTH-1:0] idx_q;
    logic [7:0]            len_q;
    logic [7:0]            cnt_q;
    logic                  err_q;

    logic aw_grant, ar_grant, wr_beat, beat_oor, cnt_last, wr_end, wr_err;

    function automatic logic [ADDR_WIDTH-1:0] word_index(input logic [ADDR_WIDTH-1:0] byte_addr);
        return byte_addr >> OFFS;
    endfunction

    // Write wins a tie unless the previous grant went to a write.
    assign aw_grant = ARESETn && (state == IDLE) && AWVALID && (!ARVALID || rr_last == RR_READ);
    assign ar_grant = ARESETn && (state == IDLE) && ARVALID && !aw_grant;
    assign AWREADY  = aw_grant;
    assign ARREADY  = ar_grant;
    assign WREADY   = (state == WR_DATA);
    assign wr_beat  = WREADY && WVALID;

`ifdef AXI_MEM_RANGE_CHK_EN
    assign beat_oor = (32'(idx_q) >= 32'(DEPTH));
`else
    assign beat_oor = 1'b0;
`endif

    assign cnt_last = (cnt_q == len_q);
    assign wr_end   = wr_beat && (cnt_last || WLAST);
    // A burst whose WLAST disagrees with the beat count ends early and reports SLVERR.
    assign wr_err   = err_q || beat_oor || (WLAST != cnt_last);

    assign mem_en    = (wr_beat || state == RD_ISSUE) && !beat_oor;
    assign mem_we    = wr_beat && !beat_oor;
    assign mem_addr  = idx_q[AW_M-1:0];
    assign mem_wdata = wr_beat ? WDATA : '0;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state   <= IDLE;
            rr_last <= RR_READ;
            idx_q   <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            BVALID  <= 1'b0;
            BRESP   <= RESP_OKAY;
            RVALID  <= 1'b0;
            RRESP   <= RESP_OKAY;
            RDATA   <= '0;
            RLAST   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (aw_grant) begin
                        idx_q   <= word_index(AWADDR);
                        len_q   <= AWLEN;
                        cnt_q   <= '0;
                        err_q   <= 1'b0;
                        rr_last <= RR_WRITE;
                        state   <= WR_DATA;
                    end else if (ar_grant) begin
                        idx_q   <= word_index(ARADDR);
                        len_q   <= ARLEN;
                        cnt_q   <= '0;
                        err_q   <= 1'b0;
                        rr_last <= RR_READ;
                        state   <= RD_ISSUE;
                    end
                end
                WR_DATA: begin
                    if (wr_beat) begin
                        idx_q <= idx_q + ADDR_WIDTH'(1);
                        cnt_q <= cnt_q + 8'd1;
                        err_q <= wr_err;
                        if (wr_end) begin
                            BVALID <= 1'b1;
                            BRESP  <= wr_err ? RESP_SLVERR : RESP_OKAY;
                            state  <= WR_RESP;
                        end
                    end
                end
                WR_RESP: begin
                    if (BREADY) begin
                        BVALID <= 1'b0;
                        state  <= IDLE;
                    end
                end
                RD_ISSUE: state <= RD_WAIT;
                RD_WAIT: begin
                    RDATA  <= beat_oor ? '0 : mem_rdata;
                    RRESP  <= beat_oor ? RESP_SLVERR : RESP_OKAY;
                    RLAST  <= cnt_last;
                    RVALID <= 1'b1;
                    state  <= RD_HOLD;
                end
                RD_HOLD: begin
                    if (RREADY) begin
                        RVALID <= 1'b0;
                        RLAST  <= 1'b0;
                        if (RLAST) begin
                            state <= IDLE;
                        end else begin
                            idx_q <= idx_q + ADDR_WIDTH'(1);
                            cnt_q <= cnt_q + 8'd1;
                            state <= RD_ISSUE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi4_mem_slave.sv
// Directed bench for axi4_mem_slave: vector table of write/read-back bursts plus corner sequences.
module tb_axi4_mem_slave;

    logic        ACLK = 1'b0;
    logic        ARESETn = 1'b0;
    logic [15:0] AWADDR = '0;
    logic [7:0]  AWLEN = '0;
    logic        AWVALID = 1'b0;
    logic        AWREADY;
    logic [31:0] WDATA = '0;
    logic        WLAST = 1'b0;
    logic        WVALID = 1'b0;
    logic        WREADY;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY = 1'b0;
    logic [15:0] ARADDR = '0;
    logic [7:0]  ARLEN = '0;
    logic        ARVALID = 1'b0;
    logic        ARREADY;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RLAST;
    logic        RVALID;
    logic        RREADY = 1'b0;
    logic        mem_en;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    axi4_mem_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .DEPTH(1024)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .AWADDR(AWADDR), .AWLEN(AWLEN), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARLEN(ARLEN), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 ACLK = ~ACLK;

    // Single-port memory with one-cycle read latency
    logic [31:0] tb_mem [0:1023];
    int wr_strobes = 0;
    always @(posedge ACLK) begin
        if (mem_en && mem_we) begin
            tb_mem[mem_addr] <= mem_wdata;
            wr_strobes <= wr_strobes + 1;
        end
        if (mem_en && !mem_we) mem_rdata <= tb_mem[mem_addr];
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic aw_send(input logic [15:0] addr, input logic [7:0] len);
        int n;
        AWADDR = addr; AWLEN = len; AWVALID = 1'b1;
        n = 0;
        do begin @(negedge ACLK); n++; end while (!AWREADY && n < 20);
        chk("awready", 32'(AWREADY), 32'd1);
        @(posedge ACLK); #1;
        AWVALID = 1'b0;
    endtask

    task automatic w_beats(input logic [31:0] base, input int nbeats);
        int n;
        for (int i = 0; i < nbeats; i++) begin
            WDATA = base + 32'(i); WLAST = (i == nbeats - 1); WVALID = 1'b1;
            n = 0;
            do begin @(negedge ACLK); n++; end while (!WREADY && n < 20);
            chk("wready", 32'(WREADY), 32'd1);
            @(posedge ACLK); #1;
        end
        WVALID = 1'b0; WLAST = 1'b0;
    endtask

    task automatic b_phase(output logic [1:0] resp);
        int n;
        BREADY = 1'b1;
        n = 0;
        do begin @(negedge ACLK); n++; end while (!BVALID && n < 20);
        chk("bvalid", 32'(BVALID), 32'd1);
        resp = BRESP;
        @(posedge ACLK); #1;
        BREADY = 1'b0;
    endtask

    task automatic write_burst(input logic [15:0] addr, input logic [7:0] len,
                               input logic [31:0] base, input int nbeats, output logic [1:0] resp);
        aw_send(addr, len);
        w_beats(base, nbeats);
        b_phase(resp);
    endtask

    task automatic r_beats(input logic [7:0] len, input logic [31:0] base,
                           input int stall_beat, input int stall_cyc, input int oor_beat);
        int n;
        logic [31:0] exp_d;
        logic [1:0]  exp_r;
        for (int i = 0; i <= int'(len); i++) begin
            exp_d = (i == oor_beat) ? 32'd0 : base + 32'(i);
            exp_r = (i == oor_beat) ? 2'b10 : 2'b00;
            RREADY = 1'b0;
            n = 0;
            do begin @(negedge ACLK); n++; end while (!RVALID && n < 20);
            chk("rvalid", 32'(RVALID), 32'd1);
            if (i == stall_beat) begin
                for (int s = 0; s < stall_cyc; s++) begin
                    chk("stall_rvalid", 32'(RVALID), 32'd1);
                    chk("stall_rdata", RDATA, exp_d);
                    @(negedge ACLK);
                end
            end
            RREADY = 1'b1;
            chk("rdata", RDATA, exp_d);
            chk("rresp", 32'(RRESP), 32'(exp_r));
            chk("rlast", 32'(RLAST), 32'(i == int'(len)));
            @(posedge ACLK); #1;
            RREADY = 1'b0;
        end
    endtask

    task automatic read_burst(input logic [15:0] addr, input logic [7:0] len, input logic [31:0] base,
                              input int stall_beat, input int stall_cyc, input int oor_beat);
        int n;
        ARADDR = addr; ARLEN = len; ARVALID = 1'b1;
        n = 0;
        do begin @(negedge ACLK); n++; end while (!ARREADY && n < 20);
        chk("arready", 32'(ARREADY), 32'd1);
        @(posedge ACLK); #1;
        ARVALID = 1'b0;
        r_beats(len, base, stall_beat, stall_cyc, oor_beat);
    endtask

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  len;
        logic [31:0] base;
        int          word0;
        int          stall_beat;
        int          stall_cyc;
    } vec_t;
    vec_t vecs[4];

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  resp;
        int          s0;
        logic [31:0] prev0;

        vecs[0] = '{addr: 16'h0010, len: 8'd3, base: 32'h0000_00A0, word0: 4,    stall_beat: 1,  stall_cyc: 5};
        vecs[1] = '{addr: 16'h0100, len: 8'd0, base: 32'h5500_0000, word0: 64,   stall_beat: -1, stall_cyc: 0};
        vecs[2] = '{addr: 16'h0FF8, len: 8'd1, base: 32'h1234_0000, word0: 1022, stall_beat: 0,  stall_cyc: 2};
        vecs[3] = '{addr: 16'h0203, len: 8'd2, base: 32'hBEEF_0000, word0: 128,  stall_beat: -1, stall_cyc: 0};

        // Reset state, with requests pending that must not be accepted
        AWVALID = 1'b1; ARVALID = 1'b1;
        repeat (2) @(negedge ACLK);
        chk("rst_awready", 32'(AWREADY), 32'd0);
        chk("rst_arready", 32'(ARREADY), 32'd0);
        chk("rst_wready", 32'(WREADY), 32'd0);
        chk("rst_bvalid", 32'(BVALID), 32'd0);
        chk("rst_bresp", 32'(BRESP), 32'd0);
        chk("rst_rvalid", 32'(RVALID), 32'd0);
        chk("rst_rresp", 32'(RRESP), 32'd0);
        chk("rst_rlast", 32'(RLAST), 32'd0);
        chk("rst_rdata", RDATA, 32'd0);
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        AWVALID = 1'b0; ARVALID = 1'b0;
        ARESETn = 1'b1;
        @(posedge ACLK); #1;

        // Write each vector, confirm memory contents, then read it back
        for (int v = 0; v < 4; v++) begin
            s0 = wr_strobes;
            write_burst(vecs[v].addr, vecs[v].len, vecs[v].base, int'(vecs[v].len) + 1, resp);
            chk("vec_bresp", 32'(resp), 32'd0);
            chk("vec_strobes", 32'(wr_strobes - s0), 32'(int'(vecs[v].len) + 1));
            for (int i = 0; i <= int'(vecs[v].len); i++)
                chk("vec_mem", tb_mem[vecs[v].word0 + i], vecs[v].base + 32'(i));
            read_burst(vecs[v].addr, vecs[v].len, vecs[v].base, vecs[v].stall_beat, vecs[v].stall_cyc, -1);
        end

        // Round-robin: first tie after reset goes to write, the next tie to read
        @(negedge ACLK); ARESETn = 1'b0;
        @(negedge ACLK); ARESETn = 1'b1;
        @(posedge ACLK); #1;
        AWADDR = 16'h0040; AWLEN = 8'd0; ARADDR = 16'h0010; ARLEN = 8'd0;
        AWVALID = 1'b1; ARVALID = 1'b1;
        @(negedge ACLK);
        chk("tie1_awready", 32'(AWREADY), 32'd1);
        chk("tie1_arready", 32'(ARREADY), 32'd0);
        @(posedge ACLK); #1;
        AWVALID = 1'b0; ARVALID = 1'b0;
        w_beats(32'h0000_0077, 1);
        b_phase(resp);
        chk("tie1_bresp", 32'(resp), 32'd0);
        chk("tie1_mem", tb_mem[16], 32'h0000_0077);
        AWVALID = 1'b1; ARVALID = 1'b1;
        @(negedge ACLK);
        chk("tie2_arready", 32'(ARREADY), 32'd1);
        chk("tie2_awready", 32'(AWREADY), 32'd0);
        @(posedge ACLK); #1;
        ARVALID = 1'b0; AWVALID = 1'b0;
        r_beats(8'd0, 32'h0000_00A0, -1, 0, -1);

        // Burst crossing the top of memory
        prev0 = tb_mem[0];
        s0 = wr_strobes;
        write_burst(16'h0FFC, 8'd1, 32'hC0DE_0000, 2, resp);
        chk("top_mem1023", tb_mem[1023], 32'hC0DE_0000);
`ifdef AXI_MEM_RANGE_CHK_EN
        chk("top_bresp", 32'(resp), 32'd2);
        chk("top_strobes", 32'(wr_strobes - s0), 32'd1);
        chk("top_mem0", tb_mem[0], prev0);
        read_burst(16'h0FFC, 8'd1, 32'hC0DE_0000, -1, 0, 1);
`else
        chk("top_bresp", 32'(resp), 32'd0);
        chk("top_strobes", 32'(wr_strobes - s0), 32'd2);
        chk("top_mem0", tb_mem[0], 32'hC0DE_0001);
        read_burst(16'h0FFC, 8'd1, 32'hC0DE_0000, -1, 0, -1);
`endif

        // Early WLAST ends the burst with SLVERR; a following write is accepted normally
        s0 = wr_strobes;
        write_burst(16'h0080, 8'd3, 32'h0000_E000, 2, resp);
        chk("early_bresp", 32'(resp), 32'd2);
        chk("early_strobes", 32'(wr_strobes - s0), 32'd2);
        write_burst(16'h0090, 8'd0, 32'h0000_F00D, 1, resp);
        chk("after_early_bresp", 32'(resp), 32'd0);
        chk("after_early_mem", tb_mem[36], 32'h0000_F00D);

        // Reset while a read beat is being held
        ARADDR = 16'h0010; ARLEN = 8'd3; ARVALID = 1'b1;
        @(negedge ACLK);
        chk("mid_arready", 32'(ARREADY), 32'd1);
        @(posedge ACLK); #1;
        ARVALID = 1'b0;
        for (int n = 0; n < 20 && !RVALID; n++) @(negedge ACLK);
        chk("mid_rvalid", 32'(RVALID), 32'd1);
        chk("mid_rdata", RDATA, 32'h0000_00A0);
        ARESETn = 1'b0;
        #1;
        chk("mid_rst_rvalid", 32'(RVALID), 32'd0);
        chk("mid_rst_rdata", RDATA, 32'd0);
        chk("mid_rst_mem_en", 32'(mem_en), 32'd0);
        @(negedge ACLK);
        ARESETn = 1'b1;
        @(posedge ACLK); #1;
        read_burst(16'h0010, 8'd3, 32'h0000_00A0, -1, 0, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
